// File: rtl/y_resp_serializer.sv
// Captures wide DUT response words into a small FIFO and streams each one out
// MSB byte first over a valid/ready byte channel, with capture/drop statistics.
module y_resp_serializer #(
   parameter int W     = 242,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] y,
   input  logic         y_valid,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic         tx_last,
   output logic         overflow,
   output logic [15:0]  drop_cnt,
   output logic [15:0]  cap_cnt,
   output logic [31:0]  sig
);

   // state  | meaning
   // S_IDLE | nothing being presented; tx_ready ignored
   // S_SEND | head entry presented byte by byte, idx selects the byte

   localparam int NB    = (W + 7) / 8;
   localparam int PW    = NB * 8;
   localparam int FW    = ((W + 31) / 32) * 32;
   localparam int NS    = FW / 32;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = AW + 1;
   localparam int IW    = (NB > 1) ? $clog2(NB) : 1;
   localparam int NBSEL = 2 ** IW;

   localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           overflow_q, overflow_d;
   logic [15:0]    drop_cnt_q, drop_cnt_d;
   logic [15:0]    cap_cnt_q, cap_cnt_d;
   logic [31:0]    sig_q, sig_d;
   logic [PW-1:0]  mem_q [DEPTH];

   logic           full;
   logic           last_byte;
   logic           hs;
   logic           pop;
   logic           accept;
   logic           drop;
   logic [PW-1:0]  p_word;
   logic [PW-1:0]  head;
   logic [31:0]    fold;
   logic [7:0]     head_bytes [NBSEL];

   function automatic logic [31:0] fold_word(input logic [W-1:0] v);
      logic [FW-1:0] e;
      logic [31:0]   f;
      e = FW'(v);
      f = 32'h0;
      for (int i = 0; i < NS; i++) begin
         f = f ^ e[i*32 +: 32];
      end
      return f;
   endfunction

   assign p_word    = PW'(y);
   assign fold      = fold_word(y);
   assign full      = (count_q == FULL_CNT);
   assign last_byte = (idx_q == LAST_IDX);
   assign hs        = (state_q == S_SEND) && tx_ready;
   assign pop       = hs && last_byte;
   // A pop on the same edge frees the slot, so a full FIFO may still accept.
   assign accept    = y_valid && (!full || pop);
   assign drop      = y_valid && !accept;
   assign head      = mem_q[rd_ptr_q];

   for (genvar g = 0; g < NBSEL; g++) begin : g_bytes
      if (g < NB) begin : g_real
         assign head_bytes[g] = head[PW-8-8*g +: 8];
      end else begin : g_pad
         assign head_bytes[g] = 8'h00;
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      cap_cnt_d  = cap_cnt_q;
      sig_d      = sig_q;
      if (accept) begin
         wr_ptr_d  = wr_ptr_q + AW'(1);
         cap_cnt_d = cap_cnt_q + 16'd1;
         sig_d     = {sig_q[30:0], sig_q[31]} ^ fold;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({accept, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               state_d = S_SEND;
               idx_d   = '0;
            end
         end
         S_SEND: begin
            if (hs) begin
               if (last_byte) begin
                  idx_d   = '0;
                  state_d = (count_d != '0) ? S_SEND : S_IDLE;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_comb begin
      tx_valid = (state_q == S_SEND);
      tx_last  = tx_valid && last_byte;
      tx_data  = tx_valid ? head_bytes[idx_q] : 8'h00;
   end

   assign overflow = overflow_q;
   assign drop_cnt = drop_cnt_q;
   assign cap_cnt  = cap_cnt_q;
   assign sig      = sig_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= 16'h0;
         cap_cnt_q  <= 16'h0;
         sig_q      <= 32'h0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
         cap_cnt_q  <= cap_cnt_d;
         sig_q      <= sig_d;
      end
   end

   // Payload storage needs no reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_q[wr_ptr_q] <= p_word;
      end
   end

endmodule

// File: tb/tb_y_resp_serializer.sv
// Randomized and directed bench for y_resp_serializer, checked every cycle
// against a word-queue model of the serializer.
module tb_y_resp_serializer;

   localparam int W     = 242;
   localparam int DEPTH = 4;
   localparam int NB    = 31;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  y;
   logic          y_valid;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          tx_last;
   logic          overflow;
   logic [15:0]   drop_cnt;
   logic [15:0]   cap_cnt;
   logic [31:0]   sig;

   always #5 clk = ~clk;

   y_resp_serializer #(.W(W), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .y        (y),
      .y_valid  (y_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_last  (tx_last),
      .overflow (overflow),
      .drop_cnt (drop_cnt),
      .cap_cnt  (cap_cnt),
      .sig      (sig)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: queue of padded words, plus the position in the head word.
   logic [247:0] mq [$];
   bit           m_active = 1'b0;
   int           m_pos    = 0;
   bit           m_ovf    = 1'b0;
   int           m_drop   = 0;
   logic [15:0]  m_cap    = 16'h0;
   logic [31:0]  m_sig    = 32'h0;
   bit           armed    = 1'b0;

   logic [7:0]   got [$];
   bit           got_last [$];
   int           hs_cnt = 0;

   function automatic logic [31:0] fold(input logic [W-1:0] v);
      logic [255:0] e;
      logic [31:0]  f;
      e = 256'(v);
      f = 32'h0;
      for (int i = 0; i < 8; i++) f = f ^ e[i*32 +: 32];
      return f;
   endfunction

   function automatic logic [7:0] byte_of(input logic [247:0] p, input int pos);
      return p[(NB-1-pos)*8 +: 8];
   endfunction

   function automatic logic [W-1:0] rand_y();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r[W-1:0];
   endfunction

   always @(negedge clk) begin : monitor
      int  size0;
      bit  fire;
      bit  pop;
      if (armed) begin
         chk("tx_valid", tx_valid, m_active);
         chk("tx_data", tx_data, m_active ? byte_of(mq[0], m_pos) : 8'h00);
         chk("tx_last", tx_last, m_active && (m_pos == NB-1));
         chk("overflow", overflow, m_ovf);
         chk("drop_cnt", drop_cnt, 16'(m_drop));
         chk("cap_cnt", cap_cnt, m_cap);
         chk("sig", sig, m_sig);
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
         got.push_back(tx_data);
         got_last.push_back(tx_last);
         hs_cnt++;
      end
      // Advance the model to the state after the coming rising edge.
      if (rst) begin
         mq.delete();
         m_active = 1'b0;
         m_pos    = 0;
         m_ovf    = 1'b0;
         m_drop   = 0;
         m_cap    = 16'h0;
         m_sig    = 32'h0;
         armed    = 1'b1;
      end else if (armed) begin
         size0 = mq.size();
         fire  = m_active && tx_ready;
         pop   = fire && (m_pos == NB-1);
         if (pop) void'(mq.pop_front());
         if (y_valid) begin
            if (size0 < DEPTH || pop) begin
               mq.push_back(248'(y));
               m_cap = m_cap + 16'd1;
               m_sig = {m_sig[30:0], m_sig[31]} ^ fold(y);
            end else begin
               m_ovf = 1'b1;
               if (m_drop < 65535) m_drop++;
            end
         end
         if (!m_active) begin
            if (size0 > 0) begin
               m_active = 1'b1;
               m_pos    = 0;
            end
         end else if (fire) begin
            if (m_pos == NB-1) begin
               m_pos    = 0;
               m_active = (mq.size() > 0);
            end else begin
               m_pos++;
            end
         end
      end
   end

   task automatic step_cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      y_valid  = 1'b0;
      tx_ready = 1'b0;
      step_cyc();
      step_cyc();
      rst = 1'b0;
      got.delete();
      got_last.delete();
      hs_cnt = 0;
   endtask

   task automatic wait_pos(input int pos, input string name);
      int n;
      n = 0;
      while (!(m_active && m_pos == pos) && n < 200) begin
         step_cyc();
         n++;
      end
      if (n >= 200) chk(name, 1'b0, 1'b1);
   endtask

   initial begin : stim
      logic [W-1:0]  w0, w1;
      logic [247:0]  p0, p1;
      logic [7:0]    held;
      logic [7:0]    acc;
      int            bad;

      rst = 1'b1; y = '0; y_valid = 1'b0; tx_ready = 1'b0;

      // Single word y=3, ready high; checks latency and byte stream.
      do_reset();
      chk("rst_tx_valid", tx_valid, 1'b0);
      chk("rst_sig", sig, 32'h0);
      y = W'(3); y_valid = 1'b1; tx_ready = 1'b1;
      step_cyc();
      chk("lat_edge_k", tx_valid, 1'b0);
      y_valid = 1'b0;
      step_cyc();
      chk("lat_edge_k1", tx_valid, 1'b1);
      repeat (40) step_cyc();
      chk("s1_nbytes", got.size(), 31);
      if (got.size() == 31) begin
         bad = 0;
         for (int i = 0; i < 30; i++) if (got[i] !== 8'h00 || got_last[i]) bad++;
         chk("s1_zero_bytes", bad, 0);
         chk("s1_final_byte", got[30], 8'h03);
         chk("s1_final_last", got_last[30], 1'b1);
      end
      chk("s1_cap_cnt", cap_cnt, 16'd1);
      chk("s1_sig", sig, 32'h3);
      chk("model_sig_pin", m_sig, 32'h3);

      // Only the two top bits set: lands in the low bits of the first byte.
      do_reset();
      y = '0; y[241:240] = 2'b11; y_valid = 1'b1; tx_ready = 1'b1;
      step_cyc();
      y_valid = 1'b0;
      repeat (40) step_cyc();
      chk("s2_nbytes", got.size(), 31);
      if (got.size() == 31) begin
         chk("s2_first_byte", got[0], 8'h03);
         acc = 8'h00;
         for (int i = 1; i < 31; i++) acc = acc | got[i];
         chk("s2_rest_zero", acc, 8'h00);
      end

      // Five captures into a stalled sink: four stored, one dropped.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         y = rand_y(); y_valid = 1'b1;
         step_cyc();
      end
      y_valid = 1'b0;
      held = tx_data;
      repeat (6) step_cyc();
      chk("s3_data_stable", tx_data, held);
      chk("s3_cap_cnt", cap_cnt, 16'd4);
      chk("s3_drop_cnt", drop_cnt, 16'd1);
      chk("s3_overflow", overflow, 1'b1);
      chk("s3_tx_valid", tx_valid, 1'b1);
      chk("s3_model_cap", m_cap, 16'd4);

      // Capture on the final-byte handshake of a full FIFO is accepted.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         y = rand_y(); y_valid = 1'b1;
         step_cyc();
      end
      y_valid = 1'b0;
      step_cyc();
      tx_ready = 1'b1;
      wait_pos(NB-1, "s4_timeout");
      chk("s4_full_before", cap_cnt, 16'd4);
      y = rand_y(); y_valid = 1'b1;
      step_cyc();
      y_valid = 1'b0;
      chk("s4_overflow", overflow, 1'b0);
      chk("s4_cap_cnt", cap_cnt, 16'd5);
      chk("s4_drop_cnt", drop_cnt, 16'd0);
      repeat (200) step_cyc();

      // Reset in the middle of a word discards the rest of it.
      do_reset();
      y = rand_y(); y_valid = 1'b1; tx_ready = 1'b1;
      step_cyc();
      y_valid = 1'b0;
      wait_pos(10, "s5_timeout");
      rst = 1'b1;
      step_cyc();
      rst = 1'b0;
      chk("s5_tx_valid", tx_valid, 1'b0);
      chk("s5_cap_cnt", cap_cnt, 16'd0);
      chk("s5_drop_cnt", drop_cnt, 16'd0);
      chk("s5_sig", sig, 32'h0);
      chk("s5_overflow", overflow, 1'b0);
      hs_cnt = 0;
      repeat (20) step_cyc();
      chk("s5_no_more_bytes", hs_cnt, 0);

      // Two words with tx_ready toggling every cycle.
      do_reset();
      w0 = rand_y(); w1 = rand_y();
      p0 = 248'(w0); p1 = 248'(w1);
      y = w0; y_valid = 1'b1;
      step_cyc();
      y = w1;
      step_cyc();
      y_valid = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tx_ready = (i % 2 == 0);
         step_cyc();
      end
      chk("s6_handshakes", hs_cnt, 62);
      if (got.size() == 62) begin
         bad = 0;
         for (int j = 0; j < 62; j++) begin
            if (got[j] !== byte_of((j < NB) ? p0 : p1, j % NB)) bad++;
         end
         chk("s6_byte_order", bad, 0);
         chk("s6_last_flags", {got_last[30], got_last[61], got_last[31]}, 3'b110);
      end

      // Random traffic with occasional resets.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         y        = rand_y();
         y_valid  = ($urandom_range(0, 99) < 25);
         tx_ready = ($urandom_range(0, 99) < 70);
         rst      = ($urandom_range(0, 999) == 0);
         step_cyc();
      end
      rst = 1'b0; y_valid = 1'b0; tx_ready = 1'b1;
      repeat (200) step_cyc();
      chk("end_idle", tx_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/y_resp_serializer.md
Y_RESP_SERIALIZER -- requirements
Module: y_resp_serializer

Interface
REQ-001 SHALL have parameter W, default 242, meaning the width of the captured DUT response word y.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of response-buffer entries (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port y, input, W bits: the DUT response word.
REQ-006 SHALL have port y_valid, input, 1 bit: capture strobe for y.
REQ-007 SHALL have port tx_data, output, 8 bits: the serialized response byte.
REQ-008 SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-009 SHALL have port tx_ready, input, 1 bit: the sink accepts the byte.
REQ-010 SHALL have port tx_last, output, 1 bit: the current byte is the final byte of a word.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag, set when a capture was dropped.
REQ-012 SHALL have port drop_cnt, output, 16 bits: the number of dropped captures, saturating at 16'hFFFF.
REQ-013 SHALL have port cap_cnt, output, 16 bits: the number of accepted captures, wrapping at 16'hFFFF.
REQ-014 SHALL have port sig, output, 32 bits: the running signature over accepted words.

Function
REQ-015 SHALL define NB = ceil(W/8) (31 for W=242), and pad y with zeros at the MSB end to NB*8 bits, giving P.
REQ-016 SHALL write P into the FIFO tail on a rising edge with y_valid=1 when the FIFO is not full, and increment cap_cnt on that edge.
REQ-017 SHALL treat a FIFO holding DEPTH entries as full; a full FIFO that completes a pop (REQ-022) on the same edge SHALL still accept the write.
REQ-018 SHALL drop the word when y_valid=1 and the FIFO is full with no same-edge pop; on that edge it SHALL set overflow and increment drop_cnt (saturating), and SHALL leave sig and cap_cnt unchanged.
REQ-019 SHALL update sig on each accepted capture as sig <= {sig[30:0],sig[31]} ^ F, where F is the XOR of the eight 32-bit slices of the 256-bit zero-extended y.
REQ-020 SHALL implement FSM states IDLE and SEND, with transitions:
- IDLE->SEND: on an edge where the FIFO is non-empty; byte index idx<=0.
- SEND->SEND: on each tx_valid&tx_ready handshake with idx<NB-1; idx increments.
- SEND->IDLE or SEND->SEND: on the handshake with idx=NB-1, the head entry pops; goes to SEND (idx=0) if a further entry remains, else IDLE.
REQ-021 SHALL drive tx_valid=1 exactly in SEND, with tx_data = P_head[(NB-idx)*8-1 -: 8] (MSB byte first) and tx_last=(idx==NB-1).
REQ-022 SHALL pop the head entry only on the handshake with tx_last=1.
REQ-023 SHALL hold tx_data and tx_last stable while tx_valid=1 and tx_ready=0.
REQ-024 SHALL give a latency of 1 cycle: with the FIFO empty, a word captured at edge k SHALL produce tx_valid=1 after edge k+1.
REQ-025 SHALL, with tx_ready held at 1, send back-to-back words with no idle cycle between them.
REQ-026 SHALL ignore tx_ready while in IDLE.

Reset
REQ-027 SHALL, on an edge with rst=1, empty the FIFO, enter IDLE, set idx=0, tx_valid=0, tx_last=0, tx_data=0, overflow=0, drop_cnt=0, cap_cnt=0 and sig=32'h0.
REQ-028 SHALL give rst priority over y_valid and tx_ready on the same edge; a word partly sent when reset arrives SHALL be discarded with no further bytes.

Verification
REQ-029 SHALL pass this scenario: one capture of y=242'h3 followed by ready=1 -> 31 bytes on consecutive cycles: 30 bytes of 8'h00, then 8'h03 with tx_last=1; cap_cnt=1; sig=32'h3.
REQ-030 SHALL pass this scenario: y with bits [241:240]=2'b11 and all other bits 0 -> first byte 8'h03 and all remaining bytes 8'h00.
REQ-031 SHALL pass this scenario: tx_ready=0 with 5 consecutive captures at DEPTH=4 -> 4 entries accepted; overflow=1, drop_cnt=1, cap_cnt=4; tx_data stable throughout.
REQ-032 SHALL pass this scenario: a capture on the same edge as the final-byte handshake while the FIFO is full -> accepted; overflow stays 0.
REQ-033 SHALL pass this scenario: rst=1 asserted at byte 10 of a word -> next cycle tx_valid=0 and all counters, sig and overflow are 0.
REQ-034 SHALL pass this scenario: tx_ready toggling 1,0,1,0 for 2 words -> each byte is delivered exactly once, in order, with 62 handshakes in total.
